// File: rtl/synaptic_accumulator.sv
// Per-neuron synaptic current accumulator with ping-pong banks: spikes sum into the active bank,
// and each timestep tick closes that bank and drains it to the neuron array one entry per beat.
module synaptic_accumulator #(
    parameter int NUM_NEURONS     = 64,
    parameter int NEURON_ID_WIDTH = 6,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int SKIP_ZERO       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_spike_valid,
    input  logic [NEURON_ID_WIDTH-1:0]  s_spike_dest_id,
    input  logic [WEIGHT_WIDTH-1:0]     s_spike_weight,
    input  logic                        s_spike_exc_inh,
    output logic                        s_spike_ready,
    input  logic                        timestep_tick,
    output logic                        m_current_valid,
    output logic [NEURON_ID_WIDTH-1:0]  m_current_neuron_id,
    output logic signed [ACC_WIDTH-1:0] m_current_value,
    input  logic                        m_current_ready,
    output logic                        drain_done,
    output logic                        tick_overrun,
    output logic [15:0]                 sat_count,
    output logic                        busy
);

    localparam int PTR_W = NEURON_ID_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_NEURONS);
    localparam logic [NEURON_ID_WIDTH:0] ID_LIMIT = (NEURON_ID_WIDTH + 1)'(NUM_NEURONS);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] bank [2][NUM_NEURONS];
    logic                        active_bank;
    logic                        drain_sel;
    logic                        pending;
    logic [PTR_W-1:0]            drain_ptr;

    logic                        spike_hit;
    logic                        spike_sat;
    logic [ACC_WIDTH-1:0]        spike_acc;
    logic [ACC_WIDTH:0]          weight_ext;
    logic [ACC_WIDTH:0]          spike_sum;
    logic [ACC_WIDTH-1:0]        spike_result;
    logic [NEURON_ID_WIDTH-1:0]  ptr_idx;
    logic [ACC_WIDTH-1:0]        drain_entry;
    logic                        out_free;
    logic                        skip_entry;
    logic                        last_entry;

    assign s_spike_ready = rst_n;
    assign busy          = (state != IDLE) || pending;
    assign drain_sel     = ~active_bank;

    // Saturating update is one bit wider than the accumulator so overflow shows up as a sign disagreement.
    always_comb begin
        spike_hit  = s_spike_valid && ({1'b0, s_spike_dest_id} < ID_LIMIT);
        spike_acc  = spike_hit ? bank[active_bank][s_spike_dest_id] : '0;
        weight_ext = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, s_spike_weight};
        if (s_spike_exc_inh) begin
            spike_sum = {spike_acc[ACC_WIDTH-1], spike_acc} + weight_ext;
        end else begin
            spike_sum = {spike_acc[ACC_WIDTH-1], spike_acc} - weight_ext;
        end
        spike_sat = spike_sum[ACC_WIDTH] != spike_sum[ACC_WIDTH-1];
        if (!spike_sat) begin
            spike_result = spike_sum[ACC_WIDTH-1:0];
        end else if (spike_sum[ACC_WIDTH]) begin
            spike_result = ACC_MIN;
        end else begin
            spike_result = ACC_MAX;
        end

        ptr_idx     = drain_ptr[NEURON_ID_WIDTH-1:0];
        drain_entry = (drain_ptr < PTR_END) ? bank[drain_sel][ptr_idx] : '0;
        out_free    = !m_current_valid || m_current_ready;
        skip_entry  = (SKIP_ZERO != 0) && (drain_entry == '0);
        last_entry  = drain_ptr == (PTR_END - PTR_W'(1));
    end

    // Spikes only ever write the active bank and the drain only clears the other one, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank                <= '{default: '0};
            active_bank         <= 1'b0;
            state               <= IDLE;
            pending             <= 1'b0;
            drain_ptr           <= '0;
            m_current_valid     <= 1'b0;
            m_current_neuron_id <= '0;
            m_current_value     <= '0;
            drain_done          <= 1'b0;
            tick_overrun        <= 1'b0;
            sat_count           <= '0;
        end else begin
            if (spike_hit) begin
                bank[active_bank][s_spike_dest_id] <= spike_result;
                if (spike_sat && (sat_count != 16'hFFFF)) begin
                    sat_count <= sat_count + 16'd1;
                end
            end

            drain_done <= 1'b0;

            if (timestep_tick) begin
                if (pending) begin
                    tick_overrun <= 1'b1;
                end else if (state != IDLE) begin
                    pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (timestep_tick || pending) begin
                        active_bank <= ~active_bank;
                        drain_ptr   <= '0;
                        pending     <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        if (drain_ptr == PTR_END) begin
                            m_current_valid <= 1'b0;
                            drain_done      <= 1'b1;
                            state           <= DONE;
                        end else begin
                            bank[drain_sel][ptr_idx] <= '0;
                            drain_ptr <= drain_ptr + PTR_W'(1);
                            if (skip_entry) begin
                                m_current_valid <= 1'b0;
                                if (last_entry) begin
                                    drain_done <= 1'b1;
                                    state      <= DONE;
                                end
                            end else begin
                                m_current_valid     <= 1'b1;
                                m_current_neuron_id <= ptr_idx;
                                m_current_value     <= drain_entry;
                            end
                        end
                    end
                end
                DONE: begin
                    if (pending) begin
                        active_bank <= ~active_bank;
                        drain_ptr   <= '0;
                        pending     <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Testbench for synaptic_accumulator: a behavioural model fills a scoreboard of expected drain beats,
// and a negedge monitor pops and compares every handshaken beat from the selected instance.
module tb_synaptic_accumulator;

    typedef struct {
        int id;
        int value;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic s_spike_valid;
    logic [5:0] s_spike_dest_id;
    logic [7:0] s_spike_weight;
    logic s_spike_exc_inh;
    logic timestep_tick;
    logic m_current_ready;

    logic main_spike_ready, main_valid, main_done, main_overrun, main_busy;
    logic [5:0] main_id;
    logic signed [15:0] main_value;
    logic [15:0] main_sat;
    logic skip_spike_ready, skip_valid, skip_done, skip_overrun, skip_busy;
    logic [5:0] skip_id;
    logic signed [15:0] skip_value;
    logic [15:0] skip_sat;

    logic sel_skip;
    logic mon_valid, mon_done;
    logic [5:0] mon_id;
    logic signed [15:0] mon_value;

    int compared = 0;
    int mismatched = 0;
    int model [64];
    int exp_sat;
    beat_t sb_q[$];
    int cyc = 0;
    int beats = 0;
    int done_count = 0;
    int done_cyc = 0;
    int last_beat_cyc = 0;
    logic prev_stall = 1'b0;
    logic [5:0] prev_id;
    logic signed [15:0] prev_value;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    synaptic_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .s_spike_valid(s_spike_valid), .s_spike_dest_id(s_spike_dest_id),
        .s_spike_weight(s_spike_weight), .s_spike_exc_inh(s_spike_exc_inh),
        .s_spike_ready(main_spike_ready), .timestep_tick(timestep_tick),
        .m_current_valid(main_valid), .m_current_neuron_id(main_id),
        .m_current_value(main_value), .m_current_ready(m_current_ready),
        .drain_done(main_done), .tick_overrun(main_overrun),
        .sat_count(main_sat), .busy(main_busy)
    );

    synaptic_accumulator #(.SKIP_ZERO(1)) dut_skip (
        .clk(clk), .rst_n(rst_n),
        .s_spike_valid(s_spike_valid), .s_spike_dest_id(s_spike_dest_id),
        .s_spike_weight(s_spike_weight), .s_spike_exc_inh(s_spike_exc_inh),
        .s_spike_ready(skip_spike_ready), .timestep_tick(timestep_tick),
        .m_current_valid(skip_valid), .m_current_neuron_id(skip_id),
        .m_current_value(skip_value), .m_current_ready(m_current_ready),
        .drain_done(skip_done), .tick_overrun(skip_overrun),
        .sat_count(skip_sat), .busy(skip_busy)
    );

    assign mon_valid = sel_skip ? skip_valid : main_valid;
    assign mon_done  = sel_skip ? skip_done  : main_done;
    assign mon_id    = sel_skip ? skip_id    : main_id;
    assign mon_value = sel_skip ? skip_value : main_value;

    // Scoreboard consumer: every handshake pops one expected beat; a stalled beat must hold next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                compared++;
                if (mon_valid !== 1'b1 || mon_id !== prev_id || mon_value !== prev_value) begin
                    mismatched++;
                    $display("[TB] FAIL hold_stable: got valid=%0b id=%0d value=%0d, want valid=1 id=%0d value=%0d",
                             mon_valid, mon_id, mon_value, prev_id, prev_value);
                end
            end
            if (mon_valid && m_current_ready) begin
                beats++;
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got id=%0d value=%0d, want no beat", mon_id, mon_value);
                end else begin
                    beat_t exp_b;
                    exp_b = sb_q.pop_front();
                    if (mon_id !== exp_b.id[5:0] || mon_value !== exp_b.value) begin
                        mismatched++;
                        $display("[TB] FAIL drain_beat: got id=%0d value=%0d, want id=%0d value=%0d",
                                 mon_id, mon_value, exp_b.id, exp_b.value);
                    end
                end
                if (mon_id == 6'd63) last_beat_cyc = cyc;
            end
            prev_stall = mon_valid && !m_current_ready;
            prev_id    = mon_id;
            prev_value = mon_value;
            if (mon_done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 0;
        exp_sat = 0;
        sb_q.delete();
    endtask

    task automatic model_spike(input int id, input int w, input bit exc);
        int v;
        if (id >= 64) return;
        v = exc ? model[id] + w : model[id] - w;
        if (v > 32767) begin
            v = 32767;
            exp_sat++;
        end else if (v < -32768) begin
            v = -32768;
            exp_sat++;
        end
        model[id] = v;
    endtask

    // Closes the modelled timestep: the bank content becomes the expected drain sequence.
    task automatic model_tick();
        beat_t b;
        for (int i = 0; i < 64; i++) begin
            if (!sel_skip || model[i] != 0) begin
                b.id = i;
                b.value = model[i];
                sb_q.push_back(b);
            end
            model[i] = 0;
        end
    endtask

    task automatic drive(input bit v, input int id, input int w, input bit exc, input bit tick);
        s_spike_valid   = v;
        s_spike_dest_id = id[5:0];
        s_spike_weight  = w[7:0];
        s_spike_exc_inh = exc;
        timestep_tick   = tick;
        if (v) model_spike(id, w, exc);
        @(posedge clk); #1;
        s_spike_valid = 1'b0;
        timestep_tick = 1'b0;
    endtask

    task automatic do_reset(input bit skip);
        sel_skip = skip;
        s_spike_valid = 1'b0;
        timestep_tick = 1'b0;
        m_current_ready = 1'b1;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = done_count >= target;
    endtask

    task automatic test_reset();
        sel_skip = 1'b0;
        s_spike_valid = 1'b0;
        s_spike_dest_id = '0;
        s_spike_weight = '0;
        s_spike_exc_inh = 1'b0;
        timestep_tick = 1'b0;
        m_current_ready = 1'b1;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (main_spike_ready !== 1'b0 || skip_spike_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready_low: got %0b/%0b, want 0/0", main_spike_ready, skip_spike_ready);
        end
        compared++;
        if ({main_valid, main_done, main_overrun, main_busy} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got valid/done/overrun/busy=%b, want 0000",
                     {main_valid, main_done, main_overrun, main_busy});
        end
        compared++;
        if (main_id !== 6'd0 || main_value !== 16'sd0 || main_sat !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got id=%0d value=%0d sat=%0d, want 0 0 0", main_id, main_value, main_sat);
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (main_spike_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ready_after_reset: got %0b, want 1", main_spike_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int start_done, start_beats;
        bit ok;
        do_reset(1'b0);
        drive(1, 3, 10, 1, 0);
        drive(1, 3, 5, 1, 0);
        drive(1, 7, 4, 0, 0);
        start_done = done_count;
        start_beats = beats;
        model_tick();
        drive(0, 0, 0, 0, 1);
        compared++;
        if (main_valid !== 1'b0 || main_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL tick_latency_e: got valid=%0b busy=%0b, want valid=0 busy=1", main_valid, main_busy);
        end
        @(posedge clk); #1;
        compared++;
        if (main_valid !== 1'b1 || main_id !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL tick_latency_e1: got valid=%0b id=%0d, want valid=1 id=0", main_valid, main_id);
        end
        wait_done(start_done + 1, 300, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL basic_done_timeout: got %0d drains, want %0d", done_count - start_done, 1);
        end
        compared++;
        if (beats - start_beats !== 64 || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL basic_beat_count: got %0d beats (%0d left), want 64 (0 left)",
                     beats - start_beats, sb_q.size());
        end
        compared++;
        if (done_cyc - last_beat_cyc !== 1) begin
            mismatched++;
            $display("[TB] FAIL done_after_last: got %0d cycles, want 1", done_cyc - last_beat_cyc);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset(1'b0);
        for (int i = 0; i < 200; i++) drive(1, 0, 255, 1, 0);
        for (int i = 0; i < 200; i++) drive(1, 1, 255, 0, 0);
        compared++;
        if (main_sat !== exp_sat[15:0]) begin
            mismatched++;
            $display("[TB] FAIL sat_count: got %0d, want %0d", main_sat, exp_sat);
        end
        model_tick();
        drive(0, 0, 0, 0, 1);
        wait_done(done_count + 1, 300, ok);
        compared++;
        if (!ok || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL sat_drain: got done=%0b left=%0d, want done=1 left=0", ok, sb_q.size());
        end
    endtask

    task automatic test_tick_with_spike();
        bit ok;
        do_reset(1'b0);
        drive(1, 5, 9, 1, 1);
        model_tick();
        wait_done(done_count + 1, 300, ok);
        drive(1, 5, 2, 1, 0);
        model_tick();
        drive(0, 0, 0, 0, 1);
        wait_done(done_count + 1, 300, ok);
        compared++;
        if (!ok || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL tick_spike_drains: got done=%0b left=%0d, want done=1 left=0", ok, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int start_done, n, sent;
        bit ok;
        do_reset(1'b0);
        drive(1, 2, 3, 1, 0);
        drive(1, 20, 100, 0, 0);
        drive(1, 63, 7, 1, 0);
        model_tick();
        drive(0, 0, 0, 0, 1);
        start_done = done_count;
        n = 0;
        sent = 0;
        while (done_count == start_done && n < 400) begin
            m_current_ready = n[0];
            drive(1, 2, 1, 1, 0);
            sent++;
            n++;
        end
        m_current_ready = 1'b1;
        compared++;
        if (done_count == start_done || sent < 64) begin
            mismatched++;
            $display("[TB] FAIL backpressure_drain: got done=%0d after %0d spikes, want done within budget",
                     done_count - start_done, sent);
        end
        model_tick();
        drive(0, 0, 0, 0, 1);
        wait_done(done_count + 1, 300, ok);
        compared++;
        if (!ok || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL backpressure_next: got done=%0b left=%0d, want done=1 left=0", ok, sb_q.size());
        end
    endtask

    task automatic test_pending_overrun();
        int start_done, busy_low, n;
        do_reset(1'b0);
        drive(1, 4, 6, 1, 0);
        model_tick();
        drive(0, 0, 0, 0, 1);
        start_done = done_count;
        drive(1, 9, 7, 1, 0);
        drive(0, 0, 0, 0, 0);
        model_tick();
        drive(0, 0, 0, 0, 1);
        compared++;
        if (main_overrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overrun_early: got %0b, want 0", main_overrun);
        end
        drive(0, 0, 0, 0, 1);
        compared++;
        if (main_overrun !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overrun_set: got %0b, want 1", main_overrun);
        end
        busy_low = 0;
        n = 0;
        while (done_count < start_done + 2 && n < 400) begin
            if (main_busy !== 1'b1) busy_low++;
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (done_count - start_done !== 2 || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL pending_drains: got %0d drains left=%0d, want 2 left=0",
                     done_count - start_done, sb_q.size());
        end
        compared++;
        if (busy_low !== 0) begin
            mismatched++;
            $display("[TB] FAIL busy_held: got %0d idle cycles, want 0", busy_low);
        end
        compared++;
        if (main_busy !== 1'b0 || main_overrun !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL after_pending: got busy=%0b overrun=%0b, want busy=0 overrun=1", main_busy, main_overrun);
        end
    endtask

    task automatic test_skip_zero();
        int start_beats;
        bit ok;
        do_reset(1'b1);
        drive(1, 40, 3, 1, 0);
        start_beats = beats;
        model_tick();
        drive(0, 0, 0, 0, 1);
        wait_done(done_count + 1, 300, ok);
        compared++;
        if (!ok || beats - start_beats !== 1 || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL skip_zero_beats: got done=%0b beats=%0d, want done=1 beats=1", ok, beats - start_beats);
        end
    endtask

    task automatic test_reset_mid_drain();
        int start_done, start_beats;
        bit ok;
        do_reset(1'b0);
        for (int i = 0; i < 130; i++) drive(1, 0, 255, 1, 0);
        m_current_ready = 1'b0;
        model_tick();
        drive(0, 0, 0, 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        compared++;
        if (main_valid !== 1'b1 || main_value !== 16'sd32767 || main_sat !== exp_sat[15:0]) begin
            mismatched++;
            $display("[TB] FAIL held_before_reset: got valid=%0b value=%0d sat=%0d, want 1 32767 %0d",
                     main_valid, main_value, main_sat, exp_sat);
        end
        start_done = done_count;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({main_valid, main_done, main_busy, main_spike_ready} !== 4'b0 || main_value !== 16'sd0
            || main_sat !== 16'd0 || main_id !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_drain: got valid=%0b done=%0b busy=%0b ready=%0b value=%0d sat=%0d, want all 0",
                     main_valid, main_done, main_busy, main_spike_ready, main_value, main_sat);
        end
        clear_model();
        m_current_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        compared++;
        if (done_count !== start_done) begin
            mismatched++;
            $display("[TB] FAIL no_done_after_abort: got %0d pulses, want 0", done_count - start_done);
        end
        start_beats = beats;
        model_tick();
        drive(0, 0, 0, 0, 1);
        wait_done(done_count + 1, 300, ok);
        compared++;
        if (!ok || beats - start_beats !== 64 || sb_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL zero_drain_after_reset: got done=%0b beats=%0d, want done=1 beats=64",
                     ok, beats - start_beats);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_tick_with_spike();
        test_back_to_back();
        test_pending_overrun();
        test_skip_zero();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/synaptic_accumulator.md
Name: synaptic_accumulator

Overview:
Downstream stage of the spike router. Consumes routed weighted spike events (dest_id, weight, exc/inh) and accumulates signed synaptic current per destination neuron for the current timestep. On each timestep tick it swaps ping-pong accumulator banks. It then drains the closed bank to the neuron array as a valid/ready stream, one neuron per beat, clearing each entry as it leaves.

Parameters:
NUM_NEURONS, 64, number of destination neurons and accumulator entries per bank
NEURON_ID_WIDTH, 6, width of neuron IDs; must satisfy 2^NEURON_ID_WIDTH >= NUM_NEURONS
WEIGHT_WIDTH, 8, unsigned synaptic weight magnitude width
ACC_WIDTH, 16, signed two's-complement accumulator width; must be > WEIGHT_WIDTH
SKIP_ZERO, 0, when 1 the drain skips entries whose value is 0

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_spike_valid  in  1  routed spike event valid
s_spike_dest_id  in  NEURON_ID_WIDTH  destination neuron
s_spike_weight  in  WEIGHT_WIDTH  unsigned weight magnitude
s_spike_exc_inh  in  1  1 = excitatory (add), 0 = inhibitory (subtract)
s_spike_ready  out  1  event accepted when valid && ready
timestep_tick  in  1  single-cycle pulse closing the current timestep
m_current_valid  out  1  drained current valid
m_current_neuron_id  out  NEURON_ID_WIDTH  neuron of drained entry
m_current_value  out  ACC_WIDTH  signed accumulated current
m_current_ready  in  1  downstream accept
drain_done  out  1  one-cycle pulse when a drain completes
tick_overrun  out  1  sticky; a tick was lost
sat_count  out  16  saturation events since reset; saturates at 16'hFFFF
busy  out  1  state != IDLE or a tick is pending

Behaviour:
- Reset (async, rst_n=0): both banks cleared to 0; active bank = 0; state IDLE; pending cleared. All outputs 0, except s_spike_ready = 0 while in reset and 1 afterwards. A reset mid-drain aborts the drain without a drain_done.
- Accumulation: s_spike_ready = 1 whenever out of reset; never stalls.
  - An accepted event updates active_bank[dest_id] at that clock edge.
  - The update is acc + weight for exc, or acc - weight for inh, computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp increments sat_count.
  - Back-to-back events to the same ID must accumulate correctly. There is no hazard because storage is flop arrays.
  - dest_id >= NUM_NEURONS is dropped and still acknowledged.
- Tick with a spike in the same cycle: the spike goes into the bank being closed, then the banks swap.
- FSM IDLE:
  - On tick (or pending tick): swap banks, drain_ptr = 0, go to DRAIN, clear pending.
- FSM DRAIN:
  - The output register loads entry drain_ptr of the drain bank when it is empty or being handshaken that cycle.
  - The drain-bank entry is cleared when loaded.
  - With SKIP_ZERO=1, zero entries advance drain_ptr by one per cycle without output.
  - Outputs are held stable while valid && !ready.
  - After the handshake of the last entry (or the last skip), go to DONE.
- FSM DONE: drain_done = 1 for one cycle; m_current_valid = 0. Go to DRAIN if pending (swapping again), else IDLE.
- Latency: tick sampled at edge E gives state DRAIN after E, and the first m_current_valid after edge E+1. A full drain with ready held high takes NUM_NEURONS cycles of valid.
- Tick while in DRAIN/DONE: set pending (one deep). A tick while pending is already set sets tick_overrun (sticky until reset) and is otherwise discarded.
- The drain bank is never written by incoming spikes.

Test Plan:
- Reset then exc events (id 3, w 10), (id 3, w 5), inh (id 7, w 4); tick with ready=1, SKIP_ZERO=0 -> 64 beats in id order 0..63: id3 = 15, id7 = -4, others 0. drain_done pulses one cycle after the id63 beat.
- ACC_WIDTH=16: 200 exc events of w=255 to id 0 -> value clamps at 32767; sat_count = 200 - 128 = 72; tick -> id0 = 32767.
- Spike (id 5, w 9) in the same cycle as tick -> drained id5 = 9, and the next timestep's id5 starts at 0.
- During a drain with ready toggling 1/0 every cycle, spikes (id 2, w 1) arrive every cycle -> outputs hold stable when ready=0, no drained value is corrupted, and the next drain shows id2 equal to the accepted count.
- Two ticks during a drain -> first is pending and auto-starts the next drain after drain_done; second sets tick_overrun = 1; busy stays 1 throughout.
- SKIP_ZERO=1 with only id 40 = 3 -> exactly one beat (id 40, 3), then drain_done; rst_n=0 mid-drain -> all outputs 0 immediately, no drain_done, and a subsequent drain outputs all zeros.
